// File: rtl/tdm_demux4_if.sv
// rtl/tdm_demux4_if.sv - serial input and parallel output bundle of the 4-slot TDM receiver
interface tdm_demux4_if #(
    parameter int W = 4
);
    logic         din;
    logic         din_valid;
    logic         sync;
    logic [W-1:0] z0;
    logic [W-1:0] z1;
    logic [W-1:0] z2;
    logic [W-1:0] z3;
    logic         frame_valid;
    logic         sync_err;
    logic         locked;

    modport master (
        output din, din_valid, sync,
        input  z0, z1, z2, z3, frame_valid, sync_err, locked
    );

    modport slave (
        input  din, din_valid, sync,
        output z0, z1, z2, z3, frame_valid, sync_err, locked
    );
endinterface

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-slot TDM serial deserialiser with frame-sync alignment
module tdm_demux4 #(
    parameter int W = 4
) (
    input  logic          clk,
    input  logic          rstn,
    tdm_demux4_if.slave   bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic {HUNT, RECV} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] bit_q, bit_d;
    logic [1:0]    slot_q, slot_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [W-1:0]  h0_q, h0_d, h1_q, h1_d, h2_q, h2_d;
    logic [W-1:0]  z0_q, z0_d, z1_q, z1_d, z2_q, z2_d, z3_q, z3_d;
    logic          fv_q, fv_d;
    logic          se_q, se_d;

    // Position the current bit is treated as occupying; forced to slot 0 bit 0
    // when a sync marker (re)starts a frame.
    logic [CW-1:0] eff_bit;
    logic [1:0]    eff_slot;
    logic [W-1:0]  word;
    logic          take_bit;

    // Framing decisions, bit shifting and frame assembly for one accepted bit.
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        slot_d   = slot_q;
        sh_d     = sh_q;
        h0_d     = h0_q;
        h1_d     = h1_q;
        h2_d     = h2_q;
        z0_d     = z0_q;
        z1_d     = z1_q;
        z2_d     = z2_q;
        z3_d     = z3_q;
        fv_d     = 1'b0;
        se_d     = 1'b0;
        eff_bit  = bit_q;
        eff_slot = slot_q;
        take_bit = 1'b0;
        word     = '0;

        if (bus.din_valid) begin
            case (state_q)
                HUNT: begin
                    if (bus.sync) begin
                        state_d  = RECV;
                        eff_bit  = '0;
                        eff_slot = 2'd0;
                        take_bit = 1'b1;
                    end
                end
                RECV: begin
                    if (bit_q == '0 && slot_q == 2'd0) begin
                        if (!bus.sync) begin
                            // Expected frame start missing: drop lock and hunt again.
                            se_d    = 1'b1;
                            state_d = HUNT;
                            bit_d   = '0;
                            slot_d  = 2'd0;
                        end else begin
                            take_bit = 1'b1;
                        end
                    end else if (bus.sync) begin
                        // Marker arrived early: abandon the partial frame and
                        // realign on this bit.
                        se_d     = 1'b1;
                        eff_bit  = '0;
                        eff_slot = 2'd0;
                        take_bit = 1'b1;
                    end else begin
                        take_bit = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // A slot's first bit starts from an empty register so stale bits never leak in.
        word = (((eff_bit == '0) ? '0 : sh_q) << 1) | W'(bus.din);

        if (take_bit) begin
            sh_d = word;
            if (eff_bit == LAST_BIT) begin
                bit_d  = '0;
                slot_d = eff_slot + 2'd1;
                case (eff_slot)
                    2'd0: h0_d = word;
                    2'd1: h1_d = word;
                    2'd2: h2_d = word;
                    default: begin
                        z0_d = h0_q;
                        z1_d = h1_q;
                        z2_d = h2_q;
                        z3_d = word;
                        fv_d = 1'b1;
                    end
                endcase
            end else begin
                bit_d  = eff_bit + CW'(1);
                slot_d = eff_slot;
            end
        end
    end

    // State, counters and output registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= HUNT;
            bit_q   <= '0;
            slot_q  <= 2'd0;
            sh_q    <= '0;
            h0_q    <= '0;
            h1_q    <= '0;
            h2_q    <= '0;
            z0_q    <= '0;
            z1_q    <= '0;
            z2_q    <= '0;
            z3_q    <= '0;
            fv_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            slot_q  <= slot_d;
            sh_q    <= sh_d;
            h0_q    <= h0_d;
            h1_q    <= h1_d;
            h2_q    <= h2_d;
            z0_q    <= z0_d;
            z1_q    <= z1_d;
            z2_q    <= z2_d;
            z3_q    <= z3_d;
            fv_q    <= fv_d;
            se_q    <= se_d;
        end
    end

    assign bus.z0          = z0_q;
    assign bus.z1          = z1_q;
    assign bus.z2          = z2_q;
    assign bus.z3          = z3_q;
    assign bus.frame_valid = fv_q;
    assign bus.sync_err    = se_q;
    assign bus.locked      = (state_q == RECV);
endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
Receive side of the team's 4-channel time-division serial link; the transmit end is a 4:1 slot multiplexer. The block deserialises a 1-bit stream carrying four W-bit slots per frame, aligns on a frame-sync marker and presents all four channel words in parallel. It distributes one line back to four outputs. A single-cycle strobe marks each completed frame.

Parameters:
W, 4, bits per slot; legal 1..16; slot word sent MSB-first.

Ports:
clk  input  1  system clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
din  input  1  serial data bit
din_valid  input  1  din/sync sampled only when 1; 0 = stall, all state held
sync  input  1  high with the first bit (MSB of slot 0) of each frame
z0  output  W  channel 0 word (slot 0)
z1  output  W  channel 1 word (slot 1)
z2  output  W  channel 2 word (slot 2)
z3  output  W  channel 3 word (slot 3)
frame_valid  output  1  one-cycle pulse: z0..z3 updated with a new complete frame
sync_err  output  1  one-cycle pulse: framing violation detected
locked  output  1  1 while in RECV state

Behaviour:
- Reset (rstn=0, async, any time incl. mid-frame): z0..z3=0, frame_valid=0, sync_err=0, locked=0, state HUNT, bit/slot counters 0, partial data discarded.
- "Accepted bit" = rising edge with din_valid=1. No state changes on edges with din_valid=0; frame_valid/sync_err still return to 0 after their one cycle.
- Internals: bit_cnt 0..W-1, slot_cnt 0..3, W-bit shift register, slot holding registers h0..h2.
- HUNT: accepted bit with sync=0 ignored. Accepted bit with sync=1 -> taken as MSB of slot 0, bit_cnt=1 (or slot_cnt advance if W=1), go RECV.
- RECV: each accepted bit shifts in MSB-first. Bit W-1 of a slot: word stored to h[slot_cnt], slot_cnt increments, bit_cnt wraps to 0.
- Last bit of slot 3: on that same edge, z0..z3 load h0,h1,h2 and the completed slot-3 word simultaneously (atomic, never partially updated); frame_valid=1 for the next cycle; counters wrap to bit 0 of slot 0; remain RECV.
- Latency: z/frame_valid visible one cycle after the final bit is presented. Back-to-back frames with no stall give frame_valid every 4*W cycles.
- Framing checks in RECV, on accepted bits only:
  - First bit of slot 0 with sync=0: sync_err pulse, bit discarded, go HUNT, locked=0.
  - sync=1 at any other bit position: sync_err pulse, partial frame discarded, this bit taken as slot-0 MSB (resync), stay RECV.
- z0..z3 hold their last complete frame through errors and HUNT. Only reset or a new complete frame changes them.
- frame_valid and sync_err are never both 1.
- locked is a registered output: 1 from the edge entering RECV, 0 from the edge entering HUNT.

Test Plan:
- Reset: hold rstn=0 with din/sync toggling -> z0..z3=0, frame_valid=0, sync_err=0, locked=0. Release -> stays HUNT until sync.
- Clean frame, W=4: sync with bit 0, slots 0xA,0x5,0xF,0x3, continuous din_valid -> locked=1 after first edge. One frame_valid pulse the cycle after bit 16 with z0=A, z1=5, z2=F, z3=3. Second back-to-back frame 1,2,4,8 -> next pulse exactly 16 cycles later.
- Stalls: same frame with din_valid=0 for 3 cycles after bit 5 and 2 cycles after bit 12 -> identical z values. frame_valid delayed by 5 cycles. No sync_err.
- Missing sync: after a good frame, next frame's first bit has sync=0 -> sync_err pulse, locked=0, z unchanged. Bits ignored until sync=1, then the following frame decodes normally.
- Early sync: sync=1 on accepted bit 7 of a frame -> sync_err pulse, no frame_valid. Next 16 bits from that point (0x1,0x2,0x3,0x4) -> z=1,2,3,4.
- Mid-frame reset: rstn pulsed low at bit 9, between clock edges -> outputs clear immediately without a clock edge, locked=0. A new frame after release decodes correctly.
